// File: rtl/ncl_ring_sync_pkg.sv
// Shared helpers for the clocked NCL ring model: rail rotation, popcount and
// code-legality check, all on zero-extended MAXW-bit vectors.
package ncl_pkg;

    localparam int LAPW = 16;
    localparam int MAXW = 32;

    function automatic logic [MAXW-1:0] rotl(input logic [MAXW-1:0] vec,
                                             input int n, input int w);
        logic [MAXW-1:0] r;
        int s;
        r = '0;
        s = n % w;
        for (int i = 0; i < MAXW; i++) begin
            if (i < w) r[(i + s) % w] = vec[i];
        end
        return r;
    endfunction

    function automatic int popcount(input logic [MAXW-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MAXW; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic logic is_onehot_or_null(input logic [MAXW-1:0] v);
        return (v & (v - MAXW'(1))) == '0;
    endfunction

endpackage

// File: rtl/ncl_ring_sync_if.sv
// Control and observation bundle of the NCL ring: stall in, tap and monitors out.
interface ncl_ring_sync_if #(
    parameter int W = 8,
    parameter int N = 5
);
    import ncl_pkg::*;

    localparam int DSW = $clog2(N + 1);

    logic            stall;
    logic [W-1:0]    tap_data;
    logic            tap_ack;
    logic [DSW-1:0]  data_stages;
    logic [LAPW-1:0] lap_cycles;
    logic            err;

    modport master (
        output stall,
        input  tap_data, tap_ack, data_stages, lap_cycles, err
    );

    modport slave (
        input  stall,
        output tap_data, tap_ack, data_stages, lap_cycles, err
    );

endinterface

// File: rtl/ncl_ring_sync_stage.sv
// One NCL ring stage: W TH22 rails with a programmable settle delay and a
// completion (all-NULL) acknowledge.
module ncl_stage #(
    parameter int             W    = 8,
    parameter logic [W-1:0]   INIT = '0,
    parameter logic [3:0]     DLY  = 4'd0
) (
    input  logic         clk,
    input  logic         init,
    input  logic         stall,
    input  logic [W-1:0] a,
    input  logic         ack_in,
    output logic [W-1:0] b,
    output logic         ack_out
);

    logic [W-1:0] b_q, b_d, target;
    logic [3:0]   cnt_q, cnt_d;
    logic         armed_q, armed_d;
    logic         pend;

    // ack high: rails may only rise; ack low: rails may only fall
    assign target = ack_in ? (a | b_q) : (a & b_q);
    assign pend   = (target != b_q);

    always_comb begin
        b_d     = b_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (armed_q) begin
            if (!pend) begin
                cnt_d   = 4'd0;
                armed_d = 1'b0;
            end else if (cnt_q <= 4'd1) begin
                b_d     = target;
                cnt_d   = 4'd0;
                armed_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (pend && cnt_q == 4'd0) begin
            if (DLY == 4'd0) begin
                b_d = target;
            end else begin
                cnt_d   = DLY;
                armed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            b_q     <= INIT;
            cnt_q   <= 4'd0;
            armed_q <= 1'b0;
        end else if (!stall) begin
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign b       = b_q;
    assign ack_out = ~|b_q;

endmodule

// File: rtl/ncl_ring_sync.sv
// N-stage clocked NCL ring with rotation at stage 0, a tap port and protocol
// monitors (occupancy, lap time, sticky illegal-code flag).
module ncl_ring_sync
    import ncl_pkg::*;
#(
    parameter int             W        = 8,
    parameter int             N        = 5,
    parameter int             ROT      = 1,
    parameter logic [N*W-1:0] INIT_VEC = ((N*W)'(4) << (3 * W)) | (N*W)'(1),
    parameter logic [N*4-1:0] DLY_VEC  = '0,
    parameter int             TAP      = 0
) (
    input  logic           clk,
    input  logic           init,
    ncl_ring_sync_if.slave sync_if
);

    localparam int DSW = $clog2(N + 1);

    logic [W-1:0] a [N];
    logic [W-1:0] b [N];
    logic [N-1:0] ack;
    logic [N-1:0] nz;
    logic [N-1:0] init_nz;

    for (genvar k = 0; k < N; k++) begin : g_stage
        if (k == 0) begin : g_rot
            assign a[k] = W'(rotl(MAXW'(b[N-1]), ROT, W));
        end else begin : g_pass
            assign a[k] = b[k-1];
        end

        ncl_stage #(
            .W    (W),
            .INIT (INIT_VEC[k*W +: W]),
            .DLY  (DLY_VEC[k*4 +: 4])
        ) u_stage (
            .clk     (clk),
            .init    (init),
            .stall   (sync_if.stall),
            .a       (a[k]),
            .ack_in  (ack[(k + 1) % N]),
            .b       (b[k]),
            .ack_out (ack[k])
        );

        assign nz[k]      = |b[k];
        assign init_nz[k] = |INIT_VEC[k*W +: W];
    end

    logic [W-1:0]    prev_q [N];
    logic [W-1:0]    tap_prev_q;
    logic [LAPW-1:0] lap_cnt_q, lap_cnt_d, lap_q, lap_d, lap_inc;
    logic [DSW-1:0]  ds_q, ds_d, ds_init;
    logic            err_q, err_d;
    logic            lap_edge, viol;

    assign ds_init  = DSW'(popcount(MAXW'(init_nz)));
    assign lap_edge = (~|tap_prev_q) & (|b[TAP]);

    // multi-hot code, or a DATA code replaced by a different DATA code
    always_comb begin
        viol = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!is_onehot_or_null(MAXW'(b[k]))) viol = 1'b1;
            if ((|b[k]) && (|prev_q[k]) && (b[k] != prev_q[k])) viol = 1'b1;
        end
    end

    always_comb begin
        lap_inc   = (lap_cnt_q == '1) ? lap_cnt_q : lap_cnt_q + LAPW'(1);
        lap_cnt_d = lap_edge ? '0 : lap_inc;
        lap_d     = lap_edge ? lap_inc : lap_q;
        ds_d      = DSW'(popcount(MAXW'(nz)));
        err_d     = err_q | viol;
    end

    always_ff @(posedge clk) begin
        if (init) begin
            for (int k = 0; k < N; k++) prev_q[k] <= INIT_VEC[k*W +: W];
            tap_prev_q <= INIT_VEC[TAP*W +: W];
            lap_cnt_q  <= '0;
            lap_q      <= '0;
            ds_q       <= ds_init;
            err_q      <= 1'b0;
        end else if (!sync_if.stall) begin
            for (int k = 0; k < N; k++) prev_q[k] <= b[k];
            tap_prev_q <= b[TAP];
            lap_cnt_q  <= lap_cnt_d;
            lap_q      <= lap_d;
            ds_q       <= ds_d;
            err_q      <= err_d;
        end
    end

    assign sync_if.tap_data    = b[TAP];
    assign sync_if.tap_ack     = ~|b[TAP];
    assign sync_if.data_stages = ds_q;
    assign sync_if.lap_cycles  = lap_q;
    assign sync_if.err         = err_q;

endmodule
